line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/display_pkg.sv | 18 +
 rtl/lbc_bank_state.sv | 30 +++
 rtl/line_buf_ctrl.sv | 136 +++++++++++++
 tb/tb_line_buf_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared line buffer constants, read-state enum and bank decode helper
package display_pkg;

    localparam int LINE_PIXELS_DEF = 100;
    localparam int ADDR_W_DEF      = 7;
    localparam int PIX_W           = 24;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } rd_state_t;

    // Decode a bank select into a one-hot pair of bank strobes
    function automatic logic [1:0] bank_onehot(input logic sel);
        return {sel, ~sel};
    endfunction

endpackage

// File: rtl/lbc_bank_state.sv
// rtl/lbc_bank_state.sv - EMPTY/FULL flags for the two ping-pong line banks
module lbc_bank_state
    import display_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       set_en,
    input  logic       set_idx,
    input  logic       clr_en,
    input  logic       clr_idx,
    output logic [1:0] bank_full
);

    logic [1:0] set_mask;
    logic [1:0] clr_mask;

    assign set_mask = set_en ? bank_onehot(set_idx) : 2'b00;
    assign clr_mask = clr_en ? bank_onehot(clr_idx) : 2'b00;

    // Writer completion marks its bank FULL, reader completion marks its bank EMPTY;
    // both may land in the same cycle because they always address different banks
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// rtl/line_buf_ctrl.sv - ping-pong line buffer controller; LBC_UNDERRUN_CNT_EN adds underrun_cnt
module line_buf_ctrl
    import display_pkg::*;
#(
    parameter int LINE_PIXELS = LINE_PIXELS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    input  logic              line_req,
    input  logic              pix_en,
    output logic [1:0]        bank_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  bank_wdata,
    output logic [1:0]        bank_re,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_sel,
    output logic              pix_valid,
    output logic              line_done,
`ifdef LBC_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    output logic              underrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_PIXELS - 1);

    logic              wr_sel;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    rd_state_t         rd_state;
    logic [1:0]        bank_full;
    logic              wr_fire;
    logic              wr_last;
    logic              rd_fire;
    logic              rd_last;
    logic              unused_wr_hi;

    // Alpha/pad byte of the host pixel is dropped
    assign unused_wr_hi = ^wr_data[31:24];

    // Writer accepts only into an EMPTY bank; held off entirely while in reset
    assign wr_ready   = reset_n & ~bank_full[wr_sel];
    assign wr_fire    = wr_valid & wr_ready;
    assign wr_last    = wr_fire && (wr_cnt == LAST_ADDR);
    assign bank_we    = wr_fire ? bank_onehot(wr_sel) : 2'b00;
    assign wr_addr    = wr_cnt;
    assign bank_wdata = wr_data[PIX_W-1:0];

    // Reads only happen while scanning a bank that was FULL at line start
    assign rd_fire = (rd_state == SCAN) & pix_en;
    assign rd_last = rd_fire && (rd_cnt == LAST_ADDR);
    assign bank_re = rd_fire ? bank_onehot(rd_sel) : 2'b00;
    assign rd_addr = rd_cnt;

    lbc_bank_state u_bank_state (
        .clock     (clock),
        .reset_n   (reset_n),
        .set_en    (wr_last),
        .set_idx   (wr_sel),
        .clr_en    (rd_last),
        .clr_idx   (rd_sel),
        .bank_full (bank_full)
    );

    // Write address counter and bank select; flips to the other bank after the last pixel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= '0;
            wr_sel <= 1'b0;
        end else if (wr_fire) begin
            if (wr_last) begin
                wr_cnt <= '0;
                wr_sel <= ~wr_sel;
            end else begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
            end
        end
    end

    // Read FSM: start a line on line_req if the read bank is FULL, scan it on pix_en
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_state  <= IDLE;
            rd_cnt    <= '0;
            rd_sel    <= 1'b0;
            pix_valid <= 1'b0;
            line_done <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            pix_valid <= rd_fire;
            line_done <= 1'b0;
            underrun  <= 1'b0;
            case (rd_state)
                IDLE: begin
                    if (line_req) begin
                        if (bank_full[rd_sel]) begin
                            rd_state <= SCAN;
                            rd_cnt   <= '0;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (rd_fire) begin
                        if (rd_last) begin
                            rd_cnt    <= '0;
                            rd_sel    <= ~rd_sel;
                            rd_state  <= IDLE;
                            line_done <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end

`ifdef LBC_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt <= 16'h0000;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb/tb_line_buf_ctrl.sv - directed self-checking bench for line_buf_ctrl
module tb_line_buf_ctrl;

    logic        clock;
    logic        reset_n;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        line_req;
    logic        pix_en;
    logic [1:0]  bank_we;
    logic [6:0]  wr_addr;
    logic [23:0] bank_wdata;
    logic [1:0]  bank_re;
    logic [6:0]  rd_addr;
    logic        rd_sel;
    logic        pix_valid;
    logic        line_done;
    logic        underrun;
`ifdef LBC_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks;
    int errors;

    line_buf_ctrl #(.LINE_PIXELS(100), .ADDR_W(7)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .line_req     (line_req),
        .pix_en       (pix_en),
        .bank_we      (bank_we),
        .wr_addr      (wr_addr),
        .bank_wdata   (bank_wdata),
        .bank_re      (bank_re),
        .rd_addr      (rd_addr),
        .rd_sel       (rd_sel),
        .pix_valid    (pix_valid),
        .line_done    (line_done),
`ifdef LBC_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .underrun     (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset;
        wr_valid = 1'b0;
        wr_data  = 32'h0;
        line_req = 1'b0;
        pix_en   = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        step;
        step;
        reset_n = 1'b1;
    endtask

    task automatic fill_bank(input logic [1:0] exp_we, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = {8'hC3, 8'h5A, 8'(i), 8'(255 - i)};
            #1;
            checks++;
            if (wr_ready !== 1'b1 || bank_we !== exp_we || wr_addr !== 7'(i) ||
                bank_wdata !== {8'h5A, 8'(i), 8'(255 - i)}) begin
                errors++;
                $display("FAIL fill_write[%0d]: got ready=%b we=%b addr=%0d data=%h expected ready=1 we=%b addr=%0d data=%h",
                         i, wr_ready, bank_we, wr_addr, bank_wdata, exp_we, i, {8'h5A, 8'(i), 8'(255 - i)});
            end
            step;
        end
        wr_valid = 1'b0;
    endtask

    task automatic start_line;
        line_req = 1'b1;
        pix_en   = 1'b0;
        step;
        line_req = 1'b0;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'hFFFF_FFFF;
        line_req = 1'b1;
        pix_en   = 1'b1;
        step;
        #1;
        checks++;
        if (bank_we !== 2'b00 || bank_re !== 2'b00 || wr_addr !== 7'd0 || rd_addr !== 7'd0) begin
            errors++;
            $display("FAIL reset_strobes: got we=%b re=%b wa=%0d ra=%0d expected 00 00 0 0",
                     bank_we, bank_re, wr_addr, rd_addr);
        end
        checks++;
        if (pix_valid !== 1'b0 || line_done !== 1'b0 || underrun !== 1'b0 || rd_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got pv=%b ld=%b ur=%b rs=%b expected 0 0 0 0",
                     pix_valid, line_done, underrun, rd_sel);
        end
        do_reset;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
        end
    endtask

    task automatic test_fill;
        do_reset;
        fill_bank(2'b01, 100);
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_100_ready: got %b expected 1", wr_ready);
        end
        fill_bank(2'b10, 100);
        wr_valid = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0 || bank_we !== 2'b00) begin
            errors++;
            $display("FAIL fill_200_blocked: got ready=%b we=%b expected 0 00", wr_ready, bank_we);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_read;
        do_reset;
        fill_bank(2'b01, 100);
        fill_bank(2'b10, 100);
        start_line;
        for (int i = 0; i < 100; i++) begin
            pix_en   = 1'b1;
            line_req = (i == 50);
            #1;
            checks++;
            if (bank_re !== 2'b01 || rd_addr !== 7'(i) || pix_valid !== (i > 0) ||
                line_done !== 1'b0 || underrun !== 1'b0) begin
                errors++;
                $display("FAIL read_scan[%0d]: got re=%b addr=%0d pv=%b ld=%b ur=%b expected re=01 addr=%0d pv=%b ld=0 ur=0",
                         i, bank_re, rd_addr, pix_valid, line_done, underrun, i, (i > 0));
            end
            step;
        end
        pix_en   = 1'b0;
        line_req = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b1 || line_done !== 1'b1 || rd_sel !== 1'b1 ||
            bank_re !== 2'b00 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_done: got pv=%b ld=%b rs=%b re=%b ready=%b expected 1 1 1 00 1",
                     pix_valid, line_done, rd_sel, bank_re, wr_ready);
        end
        step;
        #1;
        checks++;
        if (line_done !== 1'b0 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_after: got ld=%b pv=%b expected 0 0", line_done, pix_valid);
        end
    endtask

    task automatic test_underrun;
        do_reset;
        line_req = 1'b1;
        pix_en   = 1'b1;
        #1;
        checks++;
        if (bank_re !== 2'b00 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_req: got re=%b ur=%b expected 00 0", bank_re, underrun);
        end
        step;
        line_req = 1'b0;
        #1;
        checks++;
        if (underrun !== 1'b1 || bank_re !== 2'b00) begin
            errors++;
            $display("FAIL underrun_pulse: got ur=%b re=%b expected 1 00", underrun, bank_re);
        end
        step;
        #1;
        checks++;
        if (underrun !== 1'b0 || bank_re !== 2'b00) begin
            errors++;
            $display("FAIL underrun_single: got ur=%b re=%b expected 0 00", underrun, bank_re);
        end
`ifdef LBC_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 16'd1) begin
            errors++;
            $display("FAIL underrun_cnt: got %0d expected 1", underrun_cnt);
        end
`endif
        pix_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_reset;
        fill_bank(2'b01, 100);
        fill_bank(2'b10, 99);
        start_line;
        for (int i = 0; i < 99; i++) begin
            pix_en = 1'b1;
            step;
        end
        wr_valid = 1'b1;
        wr_data  = 32'h0012_3456;
        pix_en   = 1'b1;
        #1;
        checks++;
        if (bank_we !== 2'b10 || wr_addr !== 7'd99 || bank_re !== 2'b01 || rd_addr !== 7'd99) begin
            errors++;
            $display("FAIL b2b_last: got we=%b wa=%0d re=%b ra=%0d expected 10 99 01 99",
                     bank_we, wr_addr, bank_re, rd_addr);
        end
        step;
        wr_valid = 1'b0;
        pix_en   = 1'b0;
        #1;
        checks++;
        if (line_done !== 1'b1 || rd_sel !== 1'b1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got ld=%b rs=%b ready=%b expected 1 1 1", line_done, rd_sel, wr_ready);
        end
        start_line;
        pix_en = 1'b1;
        #1;
        checks++;
        if (underrun !== 1'b0 || bank_re !== 2'b10 || rd_addr !== 7'd0) begin
            errors++;
            $display("FAIL b2b_bank1_full: got ur=%b re=%b ra=%0d expected 0 10 0", underrun, bank_re, rd_addr);
        end
        pix_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset;
        fill_bank(2'b01, 100);
        start_line;
        for (int i = 0; i < 50; i++) begin
            pix_en = 1'b1;
            step;
        end
        #1;
        checks++;
        if (bank_re !== 2'b01 || rd_addr !== 7'd50) begin
            errors++;
            $display("FAIL mid_before: got re=%b ra=%0d expected 01 50", bank_re, rd_addr);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bank_re !== 2'b00 || rd_addr !== 7'd0 || pix_valid !== 1'b0 ||
            line_done !== 1'b0 || wr_addr !== 7'd0 || rd_sel !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got re=%b ra=%0d pv=%b ld=%b wa=%0d rs=%b expected 00 0 0 0 0 0",
                     bank_re, rd_addr, pix_valid, line_done, wr_addr, rd_sel);
        end
        pix_en = 1'b0;
        step;
        reset_n = 1'b1;
        start_line;
        #1;
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL mid_underrun: got %b expected 1", underrun);
        end
    endtask

    task automatic test_gapped;
        int re_count;
        int done_count;
        logic prev_fire;
        do_reset;
        fill_bank(2'b01, 100);
        start_line;
        re_count   = 0;
        done_count = 0;
        prev_fire  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            pix_en = (c % 3 == 0);
            #1;
            if (line_done === 1'b1) done_count++;
            checks++;
            if (pix_valid !== prev_fire) begin
                errors++;
                $display("FAIL gap_pix_valid[%0d]: got %b expected %b", c, pix_valid, prev_fire);
            end
            if (bank_re !== 2'b00) begin
                checks++;
                if (bank_re !== 2'b01 || rd_addr !== 7'(re_count) || pix_en !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_read[%0d]: got re=%b ra=%0d en=%b expected 01 %0d 1",
                             c, bank_re, rd_addr, pix_en, re_count);
                end
                re_count++;
            end
            prev_fire = (bank_re !== 2'b00);
            step;
        end
        pix_en = 1'b0;
        checks++;
        if (re_count !== 100 || done_count !== 1) begin
            errors++;
            $display("FAIL gap_totals: got reads=%0d done=%0d expected 100 1", re_count, done_count);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 32'h0;
        line_req = 1'b0;
        pix_en   = 1'b0;
        test_reset;
        test_fill;
        test_read;
        test_underrun;
        test_back_to_back;
        test_reset_mid;
        test_gapped;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
